// File: rtl/addsub_acc_unit_pkg.sv
// Shared definitions for the accumulator stage: opcodes, FSM encoding,
// default datapath width and the packed status-flag bundle.
package addsub_acc_unit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_ADDC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
  } flags_t;

  // Zero detect on an 8-bit slice; wider datapaths use the generic compare in the top.
  function automatic logic is_zero8(input logic [7:0] val);
    return (val == 8'h00);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor: S = X + (Y ^ {MODE}) + CI,
// with carry out and signed overflow taken from the effective operands.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             mode_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o,
  output logic             v_o
);

  logic [WIDTH-1:0] y_eff_s;
  logic [WIDTH:0]   sum_s;

  // Single adder; MODE inverts Y so SUB becomes X + ~Y + 1.
  always_comb begin
    y_eff_s = y_i ^ {WIDTH{mode_i}};
    sum_s   = {1'b0, x_i} + {1'b0, y_eff_s} + {{WIDTH{1'b0}}, ci_i};
    s_o     = sum_s[WIDTH-1:0];
    co_o    = sum_s[WIDTH];
    v_o     = (x_i[WIDTH-1] == y_eff_s[WIDTH-1]) & (sum_s[WIDTH-1] != x_i[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_acc_unit.sv
// Accumulator stage: accepts one command per valid/ready handshake, runs it
// through addsub_core in EXEC, and holds the result in RESP until consumed.
module addsub_acc_unit
  import addsub_acc_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] D,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] RESULT,
  output logic             FLAG_C,
  output logic             FLAG_Z,
  output logic             FLAG_N,
  output logic             FLAG_V
);

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  flags_t           flags_q, flags_d;

  logic             hs_s;
  logic             core_mode_s;
  logic             core_ci_s;
  logic [WIDTH-1:0] core_s_s;
  logic             core_co_s;
  logic             core_v_s;

  assign hs_s = IN_VALID & in_ready_q;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .x_i    (acc_q),
    .y_i    (opnd_q),
    .mode_i (core_mode_s),
    .ci_i   (core_ci_s),
    .s_o    (core_s_s),
    .co_o   (core_co_s),
    .v_o    (core_v_s)
  );

  // State register plus the registered handshake outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the upcoming state so they stay registered.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      ST_IDLE: in_ready_d  = 1'b1;
      ST_EXEC: in_ready_d  = 1'b0;
      ST_RESP: out_valid_d = 1'b1;
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Adder control: only SUB inverts, ADDC feeds back the last carry.
  always_comb begin
    core_mode_s = 1'b0;
    core_ci_s   = 1'b0;
    case (op_q)
      OP_SUB: begin
        core_mode_s = 1'b1;
        core_ci_s   = 1'b1;
      end
      OP_ADDC: begin
        core_mode_s = 1'b0;
        core_ci_s   = flags_q.c;
      end
      default: begin
        core_mode_s = 1'b0;
        core_ci_s   = 1'b0;
      end
    endcase
  end

  // Command capture on the input handshake.
  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    if (hs_s) begin
      op_d   = OP;
      opnd_d = D;
    end else begin
      op_d   = op_q;
      opnd_d = opnd_q;
    end
  end

  // Accumulator and flag update, only at the end of EXEC; stored carry is flags_q.c.
  always_comb begin
    acc_d   = acc_q;
    flags_d = flags_q;
    if (state_q == ST_EXEC) begin
      if (op_q == OP_LOAD) begin
        acc_d     = opnd_q;
        flags_d.c = 1'b0;
        flags_d.v = 1'b0;
      end else begin
        acc_d     = core_s_s;
        flags_d.c = core_co_s;
        flags_d.v = core_v_s;
      end
      flags_d.z = (acc_d == {WIDTH{1'b0}});
      flags_d.n = acc_d[WIDTH-1];
    end else begin
      acc_d   = acc_q;
      flags_d = flags_q;
    end
  end

  // Datapath registers; reset discards any in-flight command and result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q    <= OP_LOAD;
      opnd_q  <= {WIDTH{1'b0}};
      acc_q   <= {WIDTH{1'b0}};
      flags_q <= 4'b0000;
    end else begin
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = acc_q;
  assign FLAG_C    = flags_q.c;
  assign FLAG_Z    = flags_q.z;
  assign FLAG_N    = flags_q.n;
  assign FLAG_V    = flags_q.v;

endmodule

// File: tb/tb_addsub_acc_unit.sv
// Directed bench for addsub_acc_unit: an arithmetic model predicts every output,
// a negedge process compares the DUT against it on every cycle.
module tb_addsub_acc_unit;

  logic       CLK;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] OP;
  logic [7:0] D;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] RESULT;
  logic       FLAG_C, FLAG_Z, FLAG_N, FLAG_V;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: accumulator and carry after the last accepted command.
  logic [7:0] m_acc   = 8'h00;
  logic       m_c     = 1'b0;
  logic [3:0] m_flags = 4'b0000;

  // Expected DUT outputs at the current cycle.
  logic       exp_ir    = 1'b0;
  logic       exp_ov    = 1'b0;
  logic [7:0] exp_res   = 8'h00;
  logic [3:0] exp_flags = 4'b0000;

  addsub_acc_unit #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .OP        (OP),
    .D         (D),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .FLAG_C    (FLAG_C),
    .FLAG_Z    (FLAG_Z),
    .FLAG_N    (FLAG_N),
    .FLAG_V    (FLAG_V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned range gives carry/borrow, signed range gives overflow.
  task automatic model_apply(input logic [1:0] op, input logic [7:0] d);
    int ua, ud, sa, sd, full, ss, cin;
    logic c, v;
    logic [7:0] r;
    ua = int'(m_acc);
    ud = int'(d);
    sa = int'($signed(m_acc));
    sd = int'($signed(d));
    c = 1'b0; v = 1'b0; r = d; full = 0; ss = 0; cin = 0;
    case (op)
      2'b00: r = d;
      2'b01, 2'b11: begin
        cin  = (op == 2'b11) ? int'(m_c) : 0;
        full = ua + ud + cin;
        ss   = sa + sd + cin;
        r    = full[7:0];
        c    = (full > 255);
        v    = (ss > 127) || (ss < -128);
      end
      default: begin
        full = ua - ud;
        ss   = sa - sd;
        r    = full[7:0];
        c    = (ua >= ud);
        v    = (ss > 127) || (ss < -128);
      end
    endcase
    m_acc   = r;
    m_c     = c;
    m_flags = {c, (r == 8'h00), r[7], v};
  endtask

  // Every cycle: all outputs against the expectation.
  always @(negedge CLK) begin
    chk("in_ready",  {31'd0, IN_READY},  {31'd0, exp_ir});
    chk("out_valid", {31'd0, OUT_VALID}, {31'd0, exp_ov});
    chk("result",    {24'd0, RESULT},    {24'd0, exp_res});
    chk("flags",     {28'd0, FLAG_C, FLAG_Z, FLAG_N, FLAG_V}, {28'd0, exp_flags});
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 in EXEC.
  task automatic present(input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] lit_res, input logic [3:0] lit_flags);
    IN_VALID = 1'b1; OP = op; D = d;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    exp_ir = 1'b0;
    exp_ov = 1'b0;
    model_apply(op, d);
    chk("model_res",   {24'd0, m_acc},   {24'd0, lit_res});
    chk("model_flags", {28'd0, m_flags}, {28'd0, lit_flags});
  endtask

  task automatic to_resp();
    @(posedge CLK); #1;
    exp_ov    = 1'b1;
    exp_res   = m_acc;
    exp_flags = m_flags;
  endtask

  // Hold OUT_READY low bp cycles while poking IN_VALID, then consume.
  task automatic drain(input int bp);
    if (bp > 0) begin
      OUT_READY = 1'b0;
      for (int i = 0; i < bp; i++) begin
        IN_VALID = ~i[0]; OP = 2'b01; D = 8'hAA;
        @(posedge CLK); #1;
      end
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    exp_ov = 1'b0;
    exp_ir = 1'b1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] d, input int bp,
                     input logic [7:0] lit_res, input logic [3:0] lit_flags);
    present(op, d, lit_res, lit_flags);
    to_resp();
    drain(bp);
  endtask

  // Async reset from any point, immediate output check, release at posedge+1.
  task automatic do_reset();
    RST_N = 1'b0;
    IN_VALID = 1'b0;
    #1;
    m_acc = 8'h00; m_c = 1'b0; m_flags = 4'b0000;
    exp_ir = 1'b0; exp_ov = 1'b0; exp_res = 8'h00; exp_flags = 4'b0000;
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_result",    {24'd0, RESULT},    32'd0);
    chk("rst_in_ready",  {31'd0, IN_READY},  32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    exp_ir = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; IN_VALID = 1'b0; OP = 2'b00; D = 8'h00; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    exp_ir = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // flags literal order: {C, Z, N, V}
    cmd(2'b00, 8'h55, 0, 8'h55, 4'b0000);
    cmd(2'b01, 8'h15, 0, 8'h6A, 4'b0000);

    cmd(2'b00, 8'h55, 0, 8'h55, 4'b0000);
    cmd(2'b10, 8'h2E, 0, 8'h27, 4'b1000);
    cmd(2'b10, 8'h28, 0, 8'hFF, 4'b0010);

    cmd(2'b00, 8'h7F, 0, 8'h7F, 4'b0000);
    cmd(2'b01, 8'h01, 0, 8'h80, 4'b0011);
    cmd(2'b00, 8'h80, 0, 8'h80, 4'b0010);
    cmd(2'b10, 8'h01, 0, 8'h7F, 4'b1001);

    cmd(2'b00, 8'hFF, 0, 8'hFF, 4'b0010);
    cmd(2'b01, 8'h01, 0, 8'h00, 4'b1100);
    cmd(2'b11, 8'h00, 0, 8'h01, 4'b0000);

    // Backpressure with non-trivial flags held.
    cmd(2'b00, 8'h90, 1, 8'h90, 4'b0010);
    cmd(2'b01, 8'h90, 5, 8'h20, 4'b1001);
    cmd(2'b10, 8'h40, 3, 8'hE0, 4'b0010);
    cmd(2'b11, 8'h20, 0, 8'h00, 4'b1100);
    cmd(2'b11, 8'h7F, 2, 8'h80, 4'b0011);

    // Reset during EXEC.
    present(2'b01, 8'h10, 8'h90, 4'b0010);
    #1;
    do_reset();
    // Reset during RESP.
    present(2'b00, 8'h44, 8'h44, 4'b0000);
    to_resp();
    OUT_READY = 1'b0;
    #1;
    do_reset();
    OUT_READY = 1'b1;
    cmd(2'b01, 8'h03, 0, 8'h03, 4'b0000);

    repeat (2) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
